// File: rtl/ahb_arbiter.sv
// Round-robin, lock-aware AHB bus arbiter with a default master; request to HGRANT is 1 HREADY edge,
// HGRANT to HMASTER one more. HREADY=0 freezes all state, so bursts and locked sequences never split.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BU_INCR   = 3'b001;

  logic [MW-1:0] owner;
  logic [3:0]    beats_left;
  logic          incr_hold;

  logic [3:0]    beats_nxt;
  logic          incr_nxt;
  logic          handover;
  logic [MW-1:0] winner;
  logic          found;
  logic [MW-1:0] cand_idx;
  int            cand;

  always_comb begin
    beats_nxt = beats_left;
    incr_nxt  = incr_hold;
    case (HTRANS)
      TR_NONSEQ: begin
        incr_nxt = (HBURST == BU_INCR);
        case (HBURST)
          3'b010, 3'b011: beats_nxt = 4'd3;
          3'b100, 3'b101: beats_nxt = 4'd7;
          3'b110, 3'b111: beats_nxt = 4'd15;
          default:        beats_nxt = 4'd0;
        endcase
      end
      TR_SEQ:  beats_nxt = (beats_left == 4'd0) ? 4'd0 : beats_left - 4'd1;
      TR_BUSY: beats_nxt = beats_left;
      default: begin
        beats_nxt = 4'd0;
        incr_nxt  = 1'b0;
      end
    endcase
  end

  // An undefined-length INCR burst keeps the bus while its owner still requests.
  assign handover = (beats_nxt == 4'd0) && !HLOCK[owner] &&
                    !(incr_hold && HBUSREQ[owner] && (HTRANS != TR_IDLE));

  // Search starts just after the owner and ends on the owner itself.
  always_comb begin
    found    = 1'b0;
    winner   = MW'(DEFAULT_MASTER);
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand     = (int'(owner) + i) % NUM_MASTERS;
      cand_idx = MW'(cand);
      if (!found && HBUSREQ[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      owner      <= MW'(DEFAULT_MASTER);
      HGRANT     <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      HMASTER    <= MW'(DEFAULT_MASTER);
      HMASTLOCK  <= 1'b0;
      beats_left <= 4'd0;
      incr_hold  <= 1'b0;
    end else if (HREADY) begin
      HMASTER    <= owner;
      HMASTLOCK  <= HLOCK[owner];
      beats_left <= beats_nxt;
      if (handover && (winner != owner)) begin
        owner     <= winner;
        HGRANT    <= NUM_MASTERS'(1) << winner;
        incr_hold <= 1'b0;
      end else begin
        incr_hold <= incr_nxt;
      end
    end
  end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Bus arbiter for the multi-master AHB fabric.
- Samples per-master HBUSREQ/HLOCK and drives one-hot HGRANT, HMASTER (address/data mux select) and HMASTLOCK.
- Decides handover from the shared bus signals (HTRANS, HBURST, HREADY), so the protocol checks on the fabric (burst integrity, lock hold, grant-implies-request) hold by construction.
- Policy: round-robin, lock-aware, with a default master when the bus is idle.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16).
- DEFAULT_MASTER, 0, master granted when no HBUSREQ is asserted; also the reset owner.
- MW, $clog2(NUM_MASTERS), width of HMASTER.

Ports:
- HCLK  in  1  bus clock; all state changes on rising edge.
- HRESETn  in  1  synchronous reset, active low.
- HBUSREQ  in  NUM_MASTERS  per-master bus request.
- HLOCK  in  NUM_MASTERS  per-master locked-transfer request.
- HTRANS  in  2  muxed transfer type of the current address-phase owner (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- HBURST  in  3  muxed burst type (SINGLE=000, INCR=001, WRAP4=010, INCR4=011, WRAP8=100, INCR8=101, WRAP16=110, INCR16=111).
- HREADY  in  1  shared transfer-done.
- HGRANT  out  NUM_MASTERS  one-hot grant, registered.
- HMASTER  out  MW  index of the address-phase owner, registered.
- HMASTLOCK  out  1  current address phase is locked, registered.

Behaviour:
- Interface: one clock HCLK; reset HRESETn is synchronous, active low.
- Reset (HRESETn=0 at an HCLK edge):
  - HGRANT = one-hot DEFAULT_MASTER.
  - HMASTER = DEFAULT_MASTER.
  - HMASTLOCK = 0.
  - beats_left = 0; incr_hold = 0.
  - Reset mid-burst or mid-lock abandons all state immediately.
- Freeze: if HREADY=0, every register holds (HGRANT, HMASTER, HMASTLOCK, beats_left).
- Beat tracking, only on edges with HREADY=1:
  - NONSEQ: beats_left = len-1. len = 1 for SINGLE, 4 for WRAP4/INCR4, 8 for WRAP8/INCR8, 16 for WRAP16/INCR16. INCR sets beats_left=0 and incr_hold=1.
  - SEQ: beats_left decrements, saturating at 0.
  - BUSY: no change.
  - IDLE: beats_left=0, incr_hold=0 (early termination).
- Handover permitted at an HREADY=1 edge only when all of the following hold:
  - next beats_left == 0;
  - HLOCK[owner]=0, where owner = index of HGRANT;
  - NOT (incr_hold && HBUSREQ[owner] && HTRANS != IDLE).
- Arbitration when handover is permitted:
  - Search HBUSREQ round-robin starting at (owner+1) mod NUM_MASTERS, wrapping; the first requester wins.
  - The owner itself is the lowest-priority candidate, so it keeps the bus only if it is the sole requester.
  - If no request is asserted, grant DEFAULT_MASTER.
  - HGRANT updates at this edge; incr_hold clears if the grant moves.
- Address-phase ownership:
  - At each HREADY=1 edge, HMASTER <= index(HGRANT) as it was before that edge. HMASTER therefore lags HGRANT by one accepted transfer.
  - At the same edge, HMASTLOCK <= HLOCK[index(HGRANT)].
- Lock:
  - While the owner holds HLOCK=1, HGRANT never changes, regardless of other requests.
  - After HLOCK drops, handover is allowed once beats_left==0.
- Invariants:
  - HGRANT is always exactly one-hot.
  - HGRANT[i]=1 with HBUSREQ[i]=0 occurs only for DEFAULT_MASTER, or for a stale owner in the cycle before re-arbitration.
- Latency: request to HGRANT is 1 edge minimum (with HREADY=1 and handover permitted); HGRANT to HMASTER is 1 further HREADY=1 edge.

Test Plan:
- Reset, no requests → HGRANT=0001, HMASTER=0, HMASTLOCK=0. After 5 idle cycles, unchanged.
- HBUSREQ=1111 held, each owner issues SINGLE transfers, HREADY=1 → grant rotates 0→1→2→3→0, one step per edge. HMASTER follows one edge later.
- M1 owns the bus, issues INCR4 (NONSEQ+3 SEQ) while M2 requests, with HREADY low for 2 cycles at beat 2 → HGRANT stays 0010 through all 4 beats and the stall. It changes to 0100 at the edge accepting beat 4.
- M2 owns the bus, asserts HLOCK, does two SINGLE transfers while M0/M3 request → HGRANT stays 0100. HMASTLOCK=1 for both address phases. After HLOCK=0 and the next transfer, grant goes to M3.
- M3 starts an INCR8 burst, then issues IDLE after 3 beats → beats_left clears and handover to a pending requester occurs at that edge. Assert HRESETn=0 during an INCR16 burst → outputs return to DEFAULT_MASTER values at the next edge.
